// File: rtl/router_slice_idata_rx.sv
`default_nettype none
// ============================================================================
// Module   : router_slice_idata_rx
// Brief    : Fabric-to-router ingress receiver with a 2-entry skid buffer,
//            a head/tail framing policer and a forwarded-packet counter.
//            Optional parity check enabled by ROUTER_IDATA_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module router_slice_idata_rx #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idata_valid,
    output logic              idata_ready,
    input  logic [DATA_W-1:0] idata_data,
    input  logic              idata_head,
    input  logic              idata_tail,
`ifdef ROUTER_IDATA_PARITY_EN
    input  logic              idata_parity,
`endif
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [DATA_W-1:0] flit_data,
    output logic              flit_head,
    output logic              flit_tail,
    output logic              err_framing,
    output logic              err_parity,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int c_ENT_W = DATA_W + 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t               r_state_q, w_state_d;
    logic                 r_ready_q, w_ready_d;
    logic [1:0]           r_occ_q, w_occ_d;
    logic [c_ENT_W-1:0]   r_ent0_q, w_ent0_d;
    logic [c_ENT_W-1:0]   r_ent1_q, w_ent1_d;
    logic                 r_err_framing_q, w_err_framing_d;
    logic [CNT_W-1:0]     r_cnt_q, w_cnt_d;

    logic                 w_in_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENT_W-1:0]   w_in_ent;

    always_comb begin
        w_in_fire = idata_valid && r_ready_q;
        w_pop     = (r_occ_q != 2'd0) && flit_ready;
        // Stray body flits arriving in IDLE are consumed but never stored.
        w_push    = w_in_fire && (idata_head || (r_state_q == ST_BODY));
        w_in_ent  = {idata_data, idata_head, idata_tail};

        w_state_d = r_state_q;
        w_ent0_d  = r_ent0_q;
        w_ent1_d  = r_ent1_q;
        w_cnt_d   = r_cnt_q;

        if (w_push) begin
            w_state_d = idata_tail ? ST_IDLE : ST_BODY;
        end

        // Violation: a non-head in IDLE, or a head while a packet is open.
        w_err_framing_d = w_in_fire && (idata_head == (r_state_q == ST_BODY));

        if (w_pop) begin
            w_ent0_d = r_ent1_q;
        end
        if (w_push) begin
            if ((r_occ_q == 2'd0) || ((r_occ_q == 2'd1) && w_pop)) begin
                w_ent0_d = w_in_ent;
            end else begin
                w_ent1_d = w_in_ent;
            end
        end

        w_occ_d   = r_occ_q + 2'(w_push) - 2'(w_pop);
        w_ready_d = (w_occ_d < 2'd2);

        if (w_pop && r_ent0_q[0]) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= ST_IDLE;
            r_ready_q       <= 1'b0;
            r_occ_q         <= 2'd0;
            r_ent0_q        <= '0;
            r_ent1_q        <= '0;
            r_err_framing_q <= 1'b0;
            r_cnt_q         <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_ready_q       <= w_ready_d;
            r_occ_q         <= w_occ_d;
            r_ent0_q        <= w_ent0_d;
            r_ent1_q        <= w_ent1_d;
            r_err_framing_q <= w_err_framing_d;
            r_cnt_q         <= w_cnt_d;
        end
    end

    assign idata_ready = r_ready_q;
    assign flit_valid  = (r_occ_q != 2'd0);
    assign flit_data   = r_ent0_q[c_ENT_W-1:2];
    assign flit_head   = r_ent0_q[1];
    assign flit_tail   = r_ent0_q[0];
    assign err_framing = r_err_framing_q;
    assign pkt_count   = r_cnt_q;

`ifdef ROUTER_IDATA_PARITY_EN
    logic r_err_parity_q;
    logic w_err_parity_d;

    // Even parity: the sideband bit must equal the XOR of the payload.
    always_comb begin
        w_err_parity_d = w_in_fire && ((^idata_data) != idata_parity);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_parity_q <= 1'b0;
        end else begin
            r_err_parity_q <= w_err_parity_d;
        end
    end

    assign err_parity = r_err_parity_q;
`else
    assign err_parity = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_slice_idata_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_slice_idata_rx
// Brief    : Randomized and directed bench for router_slice_idata_rx against
//            a queue-based packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_slice_idata_rx;

    localparam int c_DATA_W = 32;
    localparam int c_CNT_W  = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                idata_valid;
    logic                idata_ready;
    logic [c_DATA_W-1:0] idata_data;
    logic                idata_head;
    logic                idata_tail;
`ifdef ROUTER_IDATA_PARITY_EN
    logic                idata_parity;
`endif
    logic                flit_valid;
    logic                flit_ready;
    logic [c_DATA_W-1:0] flit_data;
    logic                flit_head;
    logic                flit_tail;
    logic                err_framing;
    logic                err_parity;
    logic [c_CNT_W-1:0]  pkt_count;

    always #5 clk = ~clk;

    router_slice_idata_rx #(.DATA_W(c_DATA_W), .CNT_W(c_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .idata_valid (idata_valid),
        .idata_ready (idata_ready),
        .idata_data  (idata_data),
        .idata_head  (idata_head),
        .idata_tail  (idata_tail),
`ifdef ROUTER_IDATA_PARITY_EN
        .idata_parity(idata_parity),
`endif
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .flit_data   (flit_data),
        .flit_head   (flit_head),
        .flit_tail   (flit_tail),
        .err_framing (err_framing),
        .err_parity  (err_parity),
        .pkt_count   (pkt_count)
    );

    typedef struct packed {
        logic [c_DATA_W-1:0] d;
        logic                h;
        logic                t;
    } flit_t;

    // Reference model: a FIFO of flits, an "inside a packet" flag and counters.
    flit_t              m_q[$];
    bit                 m_in_pkt;
    bit                 m_ready;
    bit                 m_err_f;
    bit                 m_err_p;
    logic [c_CNT_W-1:0] m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_pkt = 0;
        m_ready  = 0;
        m_err_f  = 0;
        m_err_p  = 0;
        m_cnt    = '0;
    endtask

    task automatic check_all();
        check_eq("idata_ready", idata_ready, m_ready);
        check_eq("flit_valid", flit_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check_eq("flit_data", flit_data, m_q[0].d);
            check_eq("flit_head", flit_head, m_q[0].h);
            check_eq("flit_tail", flit_tail, m_q[0].t);
        end
        check_eq("err_framing", err_framing, m_err_f);
        check_eq("err_parity", err_parity, m_err_p);
        check_eq("pkt_count", pkt_count, m_cnt);
    endtask

    // One clock cycle: drive inputs, advance the model, sample on negedge.
    task automatic step(input bit v, input logic [c_DATA_W-1:0] d, input bit h, input bit t,
                        input bit p, input bit fr, input bit chk);
        bit fire;
        bit pop;
        idata_valid = v;
        idata_data  = d;
        idata_head  = h;
        idata_tail  = t;
`ifdef ROUTER_IDATA_PARITY_EN
        idata_parity = p;
`endif
        flit_ready  = fr;
        fire = v && m_ready;
        pop  = (m_q.size() > 0) && fr;
        @(posedge clk);
        if (pop) begin
            if (m_q[0].t) m_cnt = m_cnt + 1'b1;
            void'(m_q.pop_front());
        end
        m_err_f = 0;
        m_err_p = 0;
        if (fire) begin
            m_err_f = h ? m_in_pkt : !m_in_pkt;
            if (h || m_in_pkt) begin
                m_q.push_back('{d: d, h: h, t: t});
                m_in_pkt = !t;
            end
`ifdef ROUTER_IDATA_PARITY_EN
            m_err_p = ((^d) != p);
`endif
        end
        m_ready = m_q.size() < 2;
        @(negedge clk);
        if (chk) check_all();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        idata_valid = 1'b0;
        idata_data  = '0;
        idata_head  = 1'b0;
        idata_tail  = 1'b0;
`ifdef ROUTER_IDATA_PARITY_EN
        idata_parity = 1'b0;
`endif
        flit_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_eq("rst_ready", idata_ready, 1'b0);
        check_eq("rst_valid", flit_valid, 1'b0);
        check_eq("rst_data", flit_data, '0);
        check_eq("rst_head_tail", {flit_head, flit_tail}, 2'b00);
        check_eq("rst_errs", {err_framing, err_parity}, 2'b00);
        check_eq("rst_count", pkt_count, '0);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1);
        check_eq("ready_after_reset", idata_ready, 1'b1);

        // 3-flit packet, flit_ready high: one-cycle latency, full throughput.
        step(1, 32'hA, 1, 0, 0, 1, 1);
        check_eq("lat_a", flit_data, 32'hA);
        step(1, 32'hB, 0, 0, 0, 1, 1);
        check_eq("lat_b", flit_data, 32'hB);
        step(1, 32'hC, 0, 1, 0, 1, 1);
        check_eq("lat_c", flit_data, 32'hC);
        step(0, 0, 0, 0, 0, 1, 1);
        check_eq("pkt1_count", pkt_count, 16'd1);

        // Back-pressure: exactly two flits absorbed, then drained in order.
        step(1, 32'h11, 1, 0, 0, 0, 1);
        step(1, 32'h22, 0, 0, 0, 0, 1);
        check_eq("bp_ready_low", idata_ready, 1'b0);
        step(1, 32'h33, 0, 1, 0, 0, 1);
        step(1, 32'h33, 0, 1, 0, 0, 1);
        check_eq("bp_hold_data", flit_data, 32'h11);
        step(0, 0, 0, 0, 0, 1, 1);
        check_eq("bp_drain2", flit_data, 32'h22);
        step(1, 32'h33, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Stray body flit in IDLE: dropped and flagged.
        step(1, 32'h55, 0, 0, 0, 1, 1);
        check_eq("stray_err", err_framing, 1'b1);
        check_eq("stray_dropped", flit_valid, 1'b0);
        step(0, 0, 0, 0, 0, 1, 1);
        check_eq("stray_err_pulse", err_framing, 1'b0);

        // Head inside a packet: forwarded and flagged; tail closes it.
        step(1, 32'h61, 1, 0, 0, 1, 1);
        step(1, 32'h62, 1, 0, 0, 1, 1);
        check_eq("head_in_body_err", err_framing, 1'b1);
        step(1, 32'h63, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);

`ifdef ROUTER_IDATA_PARITY_EN
        step(1, 32'h3, 1, 1, 1, 1, 1);
        check_eq("par_bad", err_parity, 1'b1);
        step(1, 32'h3, 1, 1, 0, 1, 1);
        check_eq("par_good", err_parity, 1'b0);
        step(0, 0, 0, 0, 0, 1, 1);
`endif

        // Reset mid-packet flushes the buffer with no error pulse.
        step(1, 32'h71, 1, 0, 0, 0, 1);
        step(1, 32'h72, 0, 0, 0, 0, 1);
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7, 1);
        end
        repeat (3) step(0, 0, 0, 0, 0, 1, 1);

        // Counter wrap via single-flit packets.
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 65535; i++) begin
            step(1, $urandom, 1, 1, 0, 1, 0);
        end
        repeat (2) step(0, 0, 0, 0, 0, 1, 1);
        check_eq("cnt_max", pkt_count, 16'hFFFF);
        step(1, 32'h99, 1, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        check_eq("cnt_wrap", pkt_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_slice_idata_rx.md
# router_slice_idata_rx

Ingress receiver for the router-wrap slice: accepts flits driven from the fabric toward the router's input data port (the counterpart of the router's registered output-data path) and delivers them to the router core. A 2-entry skid buffer gives full throughput with a registered ready. A framing state machine polices head/tail ordering, drops stray body flits, and counts completed packets.

## Interface
- DATA_W, 32, flit payload width in bits (≥1)
- CNT_W, 16, width of the packet counter
- clk  input  1  slice clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- idata_valid  input  1  fabric flit valid
- idata_ready  output  1  receiver can accept; driven directly from a register
- idata_data  input  DATA_W  fabric flit payload
- idata_head  input  1  first flit of packet
- idata_tail  input  1  last flit of packet (head and tail both set = single-flit packet)
- idata_parity  input  1  even parity over idata_data (present only with ROUTER_IDATA_PARITY_EN)
- flit_valid  output  1  flit available to router
- flit_ready  input  1  router accepts flit
- flit_data  output  DATA_W  payload to router
- flit_head  output  1  head marker to router
- flit_tail  output  1  tail marker to router
- err_framing  output  1  one-cycle pulse on a framing violation
- err_parity  output  1  one-cycle pulse on a parity mismatch (constant 0 without the macro)
- pkt_count  output  CNT_W  forwarded tail flits, modulo 2^CNT_W

## Operation
- Clock and reset: single clock `clk`; reset is synchronous and active-high, named `reset`.
- Input transfer occurs when idata_valid && idata_ready. Output transfer occurs when flit_valid && flit_ready.
- Skid buffer: 2 entries, FIFO order. Each entry holds {data, head, tail}.
- idata_ready next = (occupancy after this cycle's transfers) < 2, where the occupancy counts flits that will be pushed this cycle after the framing filter.
- Framing FSM has two states, IDLE and BODY; reset state is IDLE.
  - IDLE, head flit: push the flit. If tail is also set, stay in IDLE; otherwise go to BODY.
  - IDLE, non-head flit: the flit is accepted but dropped (not pushed); err_framing pulses.
  - BODY, non-head flit: push the flit. Tail sets the next state to IDLE.
  - BODY, head flit: push the flit and pulse err_framing. Next state is BODY, or IDLE if tail is also set.
- Dropped flits still consume the input handshake, so idata_ready is unaffected by the drop.
- pkt_count increments on every output transfer with flit_tail = 1. It wraps from 2^CNT_W−1 to 0.
- Simultaneous push and pop when full: not possible, because ready is already low.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and order is preserved.

## Timing
- Reset values: idata_ready = 0, flit_valid = 0, flit_data = 0, flit_head = 0, flit_tail = 0, err_framing = 0, err_parity = 0, pkt_count = 0. The FSM is in IDLE and the buffer is empty.
- Recovery from reset: idata_ready = 1 in the first cycle after reset deasserts.
- Latency: a flit accepted in cycle N appears on flit_* in cycle N+1 when the buffer was empty.
- Throughput: one flit per cycle is sustained while flit_ready = 1.
- Back-pressure: ready drops in the cycle after the buffer reaches 2 entries. The second entry absorbs the in-flight flit.
- flit_* outputs are held stable while flit_valid = 1 and flit_ready = 0.
- err_framing and err_parity are registered and pulse in cycle N+1 for an offending flit accepted in cycle N.
- Reset mid-packet: the buffer is flushed, the FSM returns to IDLE, and any partial packet is discarded with no error pulse.

## Configuration
- ROUTER_IDATA_PARITY_EN defined:
  - The idata_parity port exists.
  - On each accepted flit, a mismatch between ^idata_data and idata_parity pulses err_parity.
  - The flit is still forwarded or dropped exactly as the FSM decides.
- ROUTER_IDATA_PARITY_EN undefined:
  - No idata_parity port.
  - err_parity is tied to 0.
  - No parity logic is present.

## Test plan
- Reset, then a 3-flit packet (head, body, tail; data 0xA, 0xB, 0xC) with flit_ready = 1 → flit_* outputs 0xA, 0xB, 0xC in cycles N+1 through N+3; pkt_count = 1; no errors.
- flit_ready = 0 while idata_valid is held high → exactly 2 flits accepted, and idata_ready = 0 from the cycle after the second accept. Releasing flit_ready drains the flits in order with no loss.
- Body flit 0x55 sent in IDLE → the flit is not forwarded, err_framing pulses once, and the FSM stays in IDLE.
- Head flit received in BODY → the flit is forwarded and err_framing pulses. A following tail gives pkt_count +1.
- pkt_count preset to 0xFFFF via 65535 single-flit packets, then one more packet → pkt_count = 0x0000.
- With the macro defined: data 0x3 with parity 1 → err_parity pulses and the flit is still forwarded. Data 0x3 with parity 0 → no pulse.
